// File: rtl/mult_seq_iter_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encodings and the legality check on the radix/width parameter pair.
package mult_seq_iter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Radix must be 1, 2 or 4 bits, must divide the width, and width >= 4.
  function automatic bit radix_legal(input int radix_bits, input int width);
    return ((radix_bits == 32'sd1) || (radix_bits == 32'sd2) || (radix_bits == 32'sd4)) &&
           (width >= 32'sd4) && ((width % radix_bits) == 32'sd0);
  endfunction

endpackage

// File: rtl/mult_seq_iter_if.sv
// Operand/result handshake bundle for mult_seq_iter. The producer/consumer
// side uses the master modport, the multiplier uses the slave modport.
interface mult_seq_iter_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 signed_mode;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic                 busy;

  modport master (
    output in_valid, signed_mode, A, B, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, signed_mode, A, B, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mult_seq_iter_step.sv
// One shift-add step: multiplies the multiplicand by a RADIX_BITS-wide digit
// of the multiplier and adds it into the accumulator at the digit's weight.
// Purely combinational so a pipelined variant can chain several copies.
module mult_seq_iter_step
  import mult_seq_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2,
  parameter int CNT_W      = 5
) (
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [RADIX_BITS-1:0] digit,
  input  logic [CNT_W-1:0]     cnt,
  output logic [2*WIDTH-1:0]   acc_next
);

  // RADIX_BITS is a power of two, so the digit weight cnt*RADIX_BITS is a shift.
  localparam int SH = $clog2(RADIX_BITS);

  logic [2*WIDTH-1:0] pp_s;
  logic [CNT_W+2:0]   shamt_s;

  // Partial product, aligned to the current digit position, added into acc.
  always_comb begin
    pp_s     = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-RADIX_BITS){1'b0}}, digit};
    shamt_s  = {3'b000, cnt} << SH;
    acc_next = acc + (pp_s << shamt_s);
  end

endmodule

// File: rtl/mult_seq_iter.sv
// Multi-cycle shift-add multiplier with valid/ready handshakes on both sides.
// Operands are reduced to magnitudes on entry, multiplied unsigned over
// WIDTH/RADIX_BITS cycles, and the sign is re-applied in a single FIX cycle.
// Fixed latency: out_valid rises N+1 edges after the input transfer.
module mult_seq_iter
  import mult_seq_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  mult_seq_iter_if.slave  bus
);

  localparam int N     = WIDTH / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] P_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  if (!radix_legal(RADIX_BITS, WIDTH)) begin : g_bad_cfg
    $error("mult_seq_iter: illegal WIDTH/RADIX_BITS combination");
  end

  logic [1:0]          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [WIDTH-1:0]    mcand_r;
  logic [WIDTH-1:0]    mplier_r;
  logic [2*WIDTH-1:0]  acc_r;
  logic                neg_r;
  logic [2*WIDTH-1:0]  result_r;
  logic                out_valid_r;
  logic                in_ready_r;
  logic                busy_r;

  logic                transfer_s;
  logic                a_neg_s;
  logic                b_neg_s;
  logic [WIDTH-1:0]    a_mag_s;
  logic [WIDTH-1:0]    b_mag_s;
  logic [2*WIDTH-1:0]  acc_next_s;
  logic [2*WIDTH-1:0]  acc_neg_s;

  // Operand magnitudes and transfer detect; -2^(W-1) maps to 2^(W-1) unsigned.
  always_comb begin
    transfer_s = bus.in_valid & in_ready_r;
    a_neg_s    = bus.signed_mode & bus.A[WIDTH-1];
    b_neg_s    = bus.signed_mode & bus.B[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = (~bus.A) + W_ONE;
    end else begin
      a_mag_s = bus.A;
    end
    if (b_neg_s) begin
      b_mag_s = (~bus.B) + W_ONE;
    end else begin
      b_mag_s = bus.B;
    end
    acc_neg_s = (~acc_r) + P_ONE;
  end

  mult_seq_iter_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS),
    .CNT_W      (CNT_W)
  ) u_step (
    .acc      (acc_r),
    .mcand    (mcand_r),
    .digit    (mplier_r[RADIX_BITS-1:0]),
    .cnt      (cnt_r),
    .acc_next (acc_next_s)
  );

  // FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      neg_r       <= 1'b0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (transfer_s) begin
            mcand_r    <= a_mag_s;
            mplier_r   <= b_mag_s;
            neg_r      <= a_neg_s ^ b_neg_s;
            acc_r      <= '0;
            cnt_r      <= '0;
            state_r    <= ST_CALC;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_r    <= acc_next_s;
          mplier_r <= mplier_r >> RADIX_BITS;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          result_r    <= neg_r ? acc_neg_s : acc_r;
          state_r     <= ST_DONE;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mult_seq_iter.sv
// Self-checking bench for mult_seq_iter: three instances (32-bit radix-2,
// 16-bit radix-1, 16-bit radix-4) checked against an arithmetic product model.
module tb_mult_seq_iter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [63:0] exp_res [3];
  bit          exp_on  [3];

  always #5 clk = ~clk;

  mult_seq_iter_if #(.WIDTH(32)) if0 ();
  mult_seq_iter_if #(.WIDTH(16)) if1 ();
  mult_seq_iter_if #(.WIDTH(16)) if2 ();

  mult_seq_iter #(.WIDTH(32), .RADIX_BITS(2)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mult_seq_iter #(.WIDTH(16), .RADIX_BITS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  mult_seq_iter #(.WIDTH(16), .RADIX_BITS(4)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

  function automatic int wid(input int s);
    return (s == 0) ? 32 : 16;
  endfunction

  function automatic int lat_exp(input int s);
    return (s == 2) ? 5 : 17;
  endfunction

  // Reference: sign-extend (or zero-extend) to 64 bits, multiply, keep 2*w bits.
  function automatic logic [63:0] model(input logic sm, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    logic [63:0] xa, xb, msk, m2;
    msk = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    m2  = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    xa  = {32'd0, a} & msk;
    xb  = {32'd0, b} & msk;
    if (sm && a[w-1]) xa = xa - (64'd1 << w);
    if (sm && b[w-1]) xb = xb - (64'd1 << w);
    return (xa * xb) & m2;
  endfunction

  function automatic logic ov(input int s);
    case (s)
      0: return if0.out_valid;
      1: return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic logic ir(input int s);
    case (s)
      0: return if0.in_ready;
      1: return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic bz(input int s);
    case (s)
      0: return if0.busy;
      1: return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [63:0] res(input int s);
    case (s)
      0: return if0.result;
      1: return {32'd0, if1.result};
      default: return {32'd0, if2.result};
    endcase
  endfunction

  task automatic drive_in(input int s, input logic v, input logic sm,
                          input logic [31:0] a, input logic [31:0] b);
    case (s)
      0: begin if0.in_valid = v; if0.signed_mode = sm; if0.A = a; if0.B = b; end
      1: begin if1.in_valid = v; if1.signed_mode = sm; if1.A = a[15:0]; if1.B = b[15:0]; end
      default: begin if2.in_valid = v; if2.signed_mode = sm; if2.A = a[15:0]; if2.B = b[15:0]; end
    endcase
  endtask

  task automatic set_ordy(input int s, input logic r);
    case (s)
      0: if0.out_ready = r;
      1: if1.out_ready = r;
      default: if2.out_ready = r;
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Wait (bounded) at a negedge until instance s is ready to accept.
  task automatic wait_ready(input int s);
    int n = 0;
    while (!ir(s) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir(s)) chk("in_ready_timeout", 64'd0, 64'd1);
  endtask

  // Wait (bounded) for out_valid, counting rising edges; returns edge count.
  task automatic wait_valid(input int s, output int lat);
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ov(s)) break;
    end
    if (!ov(s)) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  // One full transaction with optional backpressure or pre-asserted out_ready.
  task automatic run_txn(input int s, input logic sm, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input bit pre_ready);
    logic [63:0] e;
    int lat;
    e = model(sm, a, b, wid(s));
    @(negedge clk);
    wait_ready(s);
    set_ordy(s, pre_ready);
    drive_in(s, 1'b1, sm, a, b);
    @(posedge clk);
    #1;
    exp_res[s] = e;
    exp_on[s]  = 1'b1;
    drive_in(s, 1'b0, ~sm, $urandom, $urandom);
    wait_valid(s, lat);
    chk("latency", 64'(lat), 64'(lat_exp(s)));
    chk("result", res(s), e);
    if (!pre_ready) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("hold_out_valid", 64'(ov(s)), 64'd1);
        chk("hold_in_ready", 64'(ir(s)), 64'd0);
        chk("hold_result", res(s), e);
      end
      @(negedge clk);
      set_ordy(s, 1'b1);
    end
    @(posedge clk);
    #1;
    chk("handoff_out_valid", 64'(ov(s)), 64'd0);
    chk("handoff_in_ready", 64'(ir(s)), 64'd1);
    chk("kept_result", res(s), e);
    set_ordy(s, 1'b0);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] one = 32'd1;
    logic [31:0] msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return one << (w - 1);
      2: return msk;
      3: return msk >> 1;
      default: return $urandom & msk;
    endcase
  endfunction

  // Every-cycle check: handshake consistency and result of the pending op.
  always @(negedge clk) begin
    if (!reset) begin
      for (int s = 0; s < 3; s++) begin
        chk("mon_in_ready", 64'(ir(s)), 64'(!bz(s) && !ov(s)));
        if (ov(s) && exp_on[s]) chk("mon_result", res(s), exp_res[s]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int s = 0; s < 3; s++) begin
      exp_on[s] = 1'b0;
      exp_res[s] = 64'd0;
      drive_in(s, 1'b0, 1'b0, 32'd0, 32'd0);
      set_ordy(s, 1'b0);
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, asserting in_valid to show transfers are ignored in reset.
    drive_in(0, 1'b1, 1'b0, 32'd3, 32'd3);
    @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_in_ready", 64'(ir(s)), 64'd1);
      chk("rst_out_valid", 64'(ov(s)), 64'd0);
      chk("rst_busy", 64'(bz(s)), 64'd0);
      chk("rst_result", res(s), 64'd0);
    end
    drive_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Pin the model to hand-computed products.
    chk("model_u_max", model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 64'hFFFF_FFFE_0000_0001);
    chk("model_s_m3x7", model(1'b1, 32'hFFFF_FFFD, 32'd7, 32), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model_u_m3x7", model(1'b0, 32'hFFFF_FFFD, 32'd7, 32), 64'h0000_0006_FFFF_FFEB);
    chk("model_s_minsq", model(1'b1, 32'h8000_0000, 32'h8000_0000, 32), 64'h4000_0000_0000_0000);
    chk("model_s_minx1", model(1'b1, 32'h8000_0000, 32'd1, 32), 64'hFFFF_FFFF_8000_0000);
    chk("model_s16", model(1'b1, 32'h0000_FFFF, 32'h0000_8000, 16), 64'h0000_0000_0000_8000);

    // Directed 32-bit cases, including backpressure and early out_ready.
    run_txn(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    chk("lit_u_max", res(0), 64'hFFFF_FFFE_0000_0001);
    run_txn(0, 1'b1, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    chk("lit_s_m3x7", res(0), 64'hFFFF_FFFF_FFFF_FFEB);
    run_txn(0, 1'b0, 32'hFFFF_FFFD, 32'd7, 0, 1'b1);
    chk("lit_u_m3x7", res(0), 64'h0000_0006_FFFF_FFEB);
    run_txn(0, 1'b1, 32'h8000_0000, 32'h8000_0000, 5, 1'b0);
    chk("lit_s_minsq", res(0), 64'h4000_0000_0000_0000);
    run_txn(0, 1'b1, 32'h8000_0000, 32'd1, 2, 1'b1);
    chk("lit_s_minx1", res(0), 64'hFFFF_FFFF_8000_0000);

    // Reset in the middle of CALC (cnt = 8) drops the operation.
    @(negedge clk);
    wait_ready(0);
    drive_in(0, 1'b1, 1'b0, 32'd123, 32'd456);
    @(posedge clk);
    #1;
    drive_in(0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int s = 0; s < 3; s++) exp_on[s] = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(ov(0)), 64'd0);
    chk("midrst_result", res(0), 64'd0);
    chk("midrst_in_ready", 64'(ir(0)), 64'd1);
    chk("midrst_busy", 64'(bz(0)), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_txn(0, 1'b0, 32'd5, 32'd6, 0, 1'b0);
    chk("lit_after_rst", res(0), 64'd30);

    // in_valid held through DONE: no new transfer until back in IDLE.
    @(negedge clk);
    wait_ready(2);
    drive_in(2, 1'b1, 1'b0, 32'd7, 32'd9);
    @(posedge clk);
    #1;
    exp_res[2] = model(1'b0, 32'd7, 32'd9, 16);
    exp_on[2]  = 1'b1;
    wait_valid(2, lat);
    chk("held_latency", 64'(lat), 64'd5);
    repeat (3) begin
      @(negedge clk);
      chk("held_busy_done", 64'(bz(2)), 64'd0);
      chk("held_out_valid", 64'(ov(2)), 64'd1);
    end
    set_ordy(2, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(2, 1'b0);
    chk("held_idle_ready", 64'(ir(2)), 64'd1);
    chk("held_idle_busy", 64'(bz(2)), 64'd0);
    @(posedge clk);
    #1;
    chk("held_retransfer", 64'(bz(2)), 64'd1);
    drive_in(2, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_valid(2, lat);
    chk("held_second", res(2), 64'd63);
    set_ordy(2, 1'b1);
    @(posedge clk);
    #1;
    set_ordy(2, 1'b0);

    // Random sweep over both 16-bit radices, plus some 32-bit traffic.
    for (int i = 0; i < 200; i++) begin
      int s;
      s = (i % 2) + 1;
      run_txn(s, 1'($urandom_range(0, 1)), pick(16), pick(16),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 30; i++) begin
      run_txn(0, 1'($urandom_range(0, 1)), pick(32), pick(32),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
